// File: rtl/gate_bank.sv
// ---------------------------------------------------------------------------
// gate_bank
//
// Multi-channel N-input logic gate bank. Each channel reduces its INPUTS
// bits with one of four gate functions (NAND / AND / NOR / OR), and the
// whole bank's result is captured in a single-entry output register that
// uses valid/ready flow control. Optional per-channel saturating counters
// count how many accepted results had a 0 on that channel.
//
// Configuration macro:
//   GATE_BANK_CNT_EN  - when defined, the low-result counters, clr_cnt and
//                       cnt_out are active. When undefined, the counter logic
//                       is removed, cnt_out is tied to 0, and clr_cnt/cnt_sel
//                       are ignored.
//
// Parameters:
//   CHANNELS  number of independent gate channels (>= 1)
//   INPUTS    inputs per channel (>= 2)
//   CNT_W     width of each per-channel counter (>= 1)
//   SEL_W     derived counter-select width, $clog2(CHANNELS) with minimum 1
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_data/mode presented
//   in_ready   bank can accept this cycle
//   in_data    channel c uses bits [c*INPUTS +: INPUTS]
//   mode       gate function: 00 NAND, 01 AND, 10 NOR, 11 OR
//   out_valid  out_y holds an undelivered result
//   out_ready  downstream accepts out_y
//   out_y      registered gate result, bit c = channel c
//   clr_cnt    synchronous clear of all counters
//   cnt_sel    counter select
//   cnt_out    counter of channel cnt_sel (0 for out-of-range selects)
// ---------------------------------------------------------------------------
module gate_bank #(
    parameter int CHANNELS = 2,
    parameter int INPUTS   = 4,
    parameter int CNT_W    = 8,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*INPUTS-1:0]   in_data,
    input  logic [1:0]                   mode,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS-1:0]          out_y,
    input  logic                         clr_cnt,
    input  logic [SEL_W-1:0]             cnt_sel,
    output logic [CNT_W-1:0]             cnt_out
);

    localparam logic [1:0] MODE_NAND = 2'b00;
    localparam logic [1:0] MODE_AND  = 2'b01;
    localparam logic [1:0] MODE_NOR  = 2'b10;
    localparam logic [1:0] MODE_OR   = 2'b11;

    logic                accept;
    logic [CHANNELS-1:0] gate_y;

    // The output register has a single entry and no skid buffer, so a new
    // item can only enter when the register is empty or being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Combinational gate evaluation. This only feeds registers, so there is
    // no path from in_data/mode to any output port.
    always_comb begin
        gate_y = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            logic all_ones;
            logic any_one;
            all_ones = &in_data[c*INPUTS +: INPUTS];
            any_one  = |in_data[c*INPUTS +: INPUTS];
            case (mode)
                MODE_NAND: gate_y[c] = !all_ones;
                MODE_AND:  gate_y[c] = all_ones;
                MODE_NOR:  gate_y[c] = !any_one;
                MODE_OR:   gate_y[c] = any_one;
                default:   gate_y[c] = 1'b0;
            endcase
        end
    end

    // Output register. A drain without a new accept only drops out_valid;
    // out_y keeps its last value so downstream debug views stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_y     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_y     <= gate_y;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef GATE_BANK_CNT_EN

    logic [CNT_W-1:0] cnt [CHANNELS];

    // Low-result counters. Clear wins over a simultaneous increment, and a
    // counter already at all-ones stays there instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
        end else if (clr_cnt) begin
            for (int c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
        end else if (accept) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!gate_y[c] && (cnt[c] != {CNT_W{1'b1}})) begin
                    cnt[c] <= cnt[c] + 1'b1;
                end
            end
        end
    end

    // Read mux; a select that does not match any channel reads as 0.
    always_comb begin
        cnt_out = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(cnt_sel) == c) begin
                cnt_out = cnt[c];
            end
        end
    end

`else

    logic unused_cnt_inputs;

    assign unused_cnt_inputs = ^{clr_cnt, cnt_sel};
    assign cnt_out           = '0;

`endif

endmodule

// File: tb/tb_gate_bank.sv
// ---------------------------------------------------------------------------
// tb_gate_bank
//
// Self-checking bench for gate_bank with CHANNELS=2, INPUTS=4, CNT_W=2.
// A behavioural model tracks the expected output register and counters from
// the gate rules (popcount of each channel's bits), then a directed sequence
// and a randomized run are compared against the DUT.
// ---------------------------------------------------------------------------
module tb_gate_bank;

    localparam int CHANNELS = 2;
    localparam int INPUTS   = 4;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

`ifdef GATE_BANK_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                       clk;
    logic                       rst_n;
    logic                       in_valid;
    logic                       in_ready;
    logic [CHANNELS*INPUTS-1:0] in_data;
    logic [1:0]                 mode;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHANNELS-1:0]        out_y;
    logic                       clr_cnt;
    logic [0:0]                 cnt_sel;
    logic [CNT_W-1:0]           cnt_out;

    int vectors;
    int miscompares;

    // Behavioural model state
    bit                  exp_valid;
    logic [CHANNELS-1:0] exp_y;
    int                  exp_cnt [CHANNELS];

    gate_bank #(
        .CHANNELS(CHANNELS),
        .INPUTS  (INPUTS),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y),
        .clr_cnt  (clr_cnt),
        .cnt_sel  (cnt_sel),
        .cnt_out  (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate result from the number of ones in a channel
    function automatic logic gateModel(input logic [1:0] m, input int ones);
        case (m)
            2'd0:    return ones != INPUTS;
            2'd1:    return ones == INPUTS;
            2'd2:    return ones == 0;
            default: return ones != 0;
        endcase
    endfunction

    function automatic logic [CHANNELS-1:0] bankModel(input logic [1:0] m,
                                                      input logic [CHANNELS*INPUTS-1:0] d);
        logic [CHANNELS-1:0] r;
        for (int c = 0; c < CHANNELS; c++) begin
            r[c] = gateModel(m, $countones((d >> (c * INPUTS)) & ((1 << INPUTS) - 1)));
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
            $error("[TB] FAIL %s", tag);
        end
    endtask

    function automatic int expCntOut(input int s);
        if (!CNT_EN || s >= CHANNELS) return 0;
        return exp_cnt[s];
    endfunction

    task automatic modelReset();
        exp_valid = 1'b0;
        exp_y     = '0;
        for (int c = 0; c < CHANNELS; c++) exp_cnt[c] = 0;
    endtask

    // Compare registered outputs and both counter selects
    task automatic checkOutput(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        check({tag, ".out_y"}, 32'(out_y), 32'(exp_y));
        for (int s = 0; s < CHANNELS; s++) begin
            cnt_sel = 1'(s);
            #1;
            check($sformatf("%s.cnt%0d", tag, s), 32'(cnt_out), 32'(expCntOut(s)));
        end
    endtask

    // One clock of stimulus: drive, check in_ready, advance model, clock,
    // then check the registered outputs at the falling edge.
    task automatic applyStimulus(input string tag, input logic iv,
                                 input logic [CHANNELS*INPUTS-1:0] d, input logic [1:0] m,
                                 input logic ordy, input logic clr);
        bit                  acc;
        logic [CHANNELS-1:0] ny;
        in_valid  = iv;
        in_data   = d;
        mode      = m;
        out_ready = ordy;
        clr_cnt   = clr;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!exp_valid || ordy));
        acc = iv && (!exp_valid || ordy);
        ny  = bankModel(m, d);
        if (clr) begin
            for (int c = 0; c < CHANNELS; c++) exp_cnt[c] = 0;
        end else if (acc) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!ny[c] && exp_cnt[c] < CNT_MAX) exp_cnt[c]++;
            end
        end
        if (acc) begin
            exp_valid = 1'b1;
            exp_y     = ny;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        in_valid    = 1'b0;
        in_data     = '0;
        mode        = 2'b00;
        out_ready   = 1'b0;
        clr_cnt     = 1'b0;
        cnt_sel     = 1'b0;
        rst_n       = 1'b0;
        modelReset();

        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Idle after reset
        applyStimulus("idle", 1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

        // NAND with mixed channels
        applyStimulus("nand_f7", 1'b1, 8'hF7, 2'b00, 1'b1, 1'b0);

        // Each mode on one all-ones and one all-zeros channel
        applyStimulus("nand_0f", 1'b1, 8'h0F, 2'b00, 1'b1, 1'b0);
        applyStimulus("and_0f",  1'b1, 8'h0F, 2'b01, 1'b1, 1'b0);
        applyStimulus("nor_0f",  1'b1, 8'h0F, 2'b10, 1'b1, 1'b0);
        applyStimulus("or_0f",   1'b1, 8'h0F, 2'b11, 1'b1, 1'b0);
        applyStimulus("drain",   1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

        // Backpressure: second item waits until out_ready rises
        applyStimulus("bp_first",  1'b1, 8'h3C, 2'b11, 1'b0, 1'b0);
        applyStimulus("bp_hold1",  1'b1, 8'hF0, 2'b01, 1'b0, 1'b0);
        applyStimulus("bp_hold2",  1'b1, 8'hF0, 2'b01, 1'b0, 1'b0);
        applyStimulus("bp_accept", 1'b1, 8'hF0, 2'b01, 1'b1, 1'b0);
        applyStimulus("bp_drain",  1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

        // Saturation then clear racing an accept
        applyStimulus("clr_idle", 1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("sat%0d", i), 1'b1, 8'hFF, 2'b00, 1'b1, 1'b0);
        end
        applyStimulus("clr_acc", 1'b1, 8'hFF, 2'b00, 1'b1, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                          8'($urandom), 2'($urandom), 1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset while a result is pending
        applyStimulus("pre_rst0", 1'b1, 8'h00, 2'b00, 1'b1, 1'b0);
        applyStimulus("pre_rst1", 1'b1, 8'h5A, 2'b10, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        check("async_rst.in_ready", 32'(in_ready), 32'(1));
        checkOutput("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_rst", 1'b1, 8'h0F, 2'b01, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
